// File: rtl/melody_pkg.sv
// Shared types and constants for the melody player: FSM states,
// the base note frequencies of octave 4 and the half-period helper.
package melody_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_PLAY  = 2'd2,
      ST_PAUSE = 2'd3
   } state_e;

   // Frequency reported while nothing audible is playing.
   localparam logic [31:0] SILENCE_HZ = 32'd20000;

   // Base frequency in Hz of scale degree d (C4..B4).
   function automatic logic [31:0] base_hz(input logic [2:0] d);
      case (d)
         3'd0:    return 32'd262;
         3'd1:    return 32'd294;
         3'd2:    return 32'd330;
         3'd3:    return 32'd349;
         3'd4:    return 32'd392;
         3'd5:    return 32'd440;
         3'd6:    return 32'd494;
         default: return 32'd262;
      endcase
   endfunction

   // Clock cycles per half wave of degree d in octave 4.
   function automatic int unsigned half_period_of(input int unsigned clk_hz,
                                                  input logic [2:0] d);
      return clk_hz / (2 * base_hz(d));
   endfunction

endpackage

// File: rtl/melody_player_note_decode.sv
// Combinational note index decoder: index -> silent flag, tone in Hz and
// half period in clock cycles. Index 1..7 is C4..B4, each further group
// of 7 is one octave up; 0 or anything above the top note is silence.
module note_decode
   import melody_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned NOTE_W  = 8,
   parameter int unsigned OCTAVES = 5,
   parameter int unsigned HP_W    = 18
) (
   input  logic [NOTE_W-1:0] note,
   output logic              silent,
   output logic [31:0]       tone,
   output logic [HP_W-1:0]   half_period
);

   localparam logic [NOTE_W-1:0] TOP_NOTE = NOTE_W'(7 * OCTAVES);
   localparam logic [NOTE_W-1:0] SEVEN    = NOTE_W'(7);

   logic [NOTE_W-1:0] idx_m1;
   logic [2:0]        degree;
   logic [NOTE_W-1:0] octave;
   logic [HP_W-1:0]   hp_base;

   // Split the index into degree/octave and scale the octave-4 values.
   always_comb begin
      idx_m1 = note - 1'b1;
      degree = 3'(idx_m1 % SEVEN);
      octave = idx_m1 / SEVEN;
      silent = (note == '0) || (note > TOP_NOTE);
      case (degree)
         3'd0:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd0));
         3'd1:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd1));
         3'd2:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd2));
         3'd3:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd3));
         3'd4:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd4));
         3'd5:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd5));
         3'd6:    hp_base = HP_W'(half_period_of(CLK_HZ, 3'd6));
         default: hp_base = HP_W'(half_period_of(CLK_HZ, 3'd0));
      endcase
      if (silent) begin
         tone        = SILENCE_HZ;
         half_period = hp_base;
      end else begin
         tone        = base_hz(degree) << octave;
         half_period = hp_base >> octave;
      end
   end

endmodule

// File: rtl/melody_player.sv
// Melody player: steps through an external song ROM one note per beat and
// drives a square wave for each note, with play/pause/stop and loop mode.
// Pause only freezes time: the cycle pause drops, counting resumes at once.
module melody_player
   import melody_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100_000_000,
   parameter int unsigned BEAT_HZ = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned NOTE_W  = 8,
   parameter int unsigned OCTAVES = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] song_len,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [NOTE_W-1:0] rom_note,
   output logic [31:0]       tone,
   output logic              audio,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CPB    = CLK_HZ / BEAT_HZ;
   localparam int unsigned BEAT_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int unsigned HP0    = half_period_of(CLK_HZ, 3'd0);
   localparam int unsigned HP_W   = $clog2(HP0 + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       tone_q, tone_d;
   logic [HP_W-1:0]   hp_q, hp_d;
   logic [HP_W-1:0]   wave_q, wave_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              silent_q, silent_d;
   logic              audio_q, audio_d;
   logic              done_q, done_d;

   logic              dec_silent;
   logic [31:0]       dec_tone;
   logic [HP_W-1:0]   dec_hp;
   logic              running;
   logic              beat_end;
   logic              last_note;

   note_decode #(
      .CLK_HZ  (CLK_HZ),
      .NOTE_W  (NOTE_W),
      .OCTAVES (OCTAVES),
      .HP_W    (HP_W)
   ) u_note_decode (
      .note        (rom_note),
      .silent      (dec_silent),
      .tone        (dec_tone),
      .half_period (dec_hp)
   );

   // Next-state logic: stop beats start beats pause; beat end advances.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      tone_d   = tone_q;
      hp_d     = hp_q;
      wave_d   = wave_q;
      beat_d   = beat_q;
      silent_d = silent_q;
      audio_d  = audio_q;
      done_d   = 1'b0;
      running   = ((state_q == ST_PLAY) || (state_q == ST_PAUSE)) && !pause;
      beat_end  = (beat_q == BEAT_W'(CPB - 1));
      last_note = (addr_q == song_len - 1'b1);
      if (stop) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         tone_d  = SILENCE_HZ;
         audio_d = 1'b0;
         wave_d  = '0;
         beat_d  = '0;
      end else if (start && (song_len != '0)) begin
         state_d = ST_FETCH;
         addr_d  = '0;
         audio_d = 1'b0;
         wave_d  = '0;
         beat_d  = '0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               state_d  = ST_PLAY;
               tone_d   = dec_tone;
               hp_d     = dec_hp;
               silent_d = dec_silent;
               wave_d   = '0;
               beat_d   = '0;
               audio_d  = 1'b0;
            end
            ST_PLAY, ST_PAUSE: begin
               if (!running) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_PLAY;
                  if (!silent_q) begin
                     if (wave_q == hp_q - 1'b1) begin
                        wave_d  = '0;
                        audio_d = ~audio_q;
                     end else begin
                        wave_d = wave_q + 1'b1;
                     end
                  end
                  if (beat_end) begin
                     beat_d  = '0;
                     wave_d  = '0;
                     audio_d = 1'b0;
                     if (!last_note) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_FETCH;
                     end else if (loop_en) begin
                        addr_d  = '0;
                        state_d = ST_FETCH;
                     end else begin
                        addr_d  = '0;
                        state_d = ST_IDLE;
                        tone_d  = SILENCE_HZ;
                        done_d  = 1'b1;
                     end
                  end else begin
                     beat_d = beat_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and registered outputs; reset returns everything to silence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         tone_q   <= SILENCE_HZ;
         hp_q     <= '0;
         wave_q   <= '0;
         beat_q   <= '0;
         silent_q <= 1'b1;
         audio_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         tone_q   <= tone_d;
         hp_q     <= hp_d;
         wave_q   <= wave_d;
         beat_q   <= beat_d;
         silent_q <= silent_d;
         audio_q  <= audio_d;
         done_q   <= done_d;
      end
   end

   assign rom_addr = addr_q;
   assign tone     = tone_q;
   assign audio    = audio_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player at 100 kHz clock / 100 beats per second.
module tb_melody_player;

   localparam int CLK_HZ  = 100_000;
   localparam int BEAT_HZ = 100;
   localparam int CPB     = CLK_HZ / BEAT_HZ;

   logic        clk = 1'b0;
   logic        rst, start, pause, stop, loop_en;
   logic [7:0]  song_len, rom_addr, rom_note;
   logic [31:0] tone;
   logic        audio, busy, done;

   logic [7:0]  rom [256];
   assign rom_note = rom[rom_addr];

   melody_player #(
      .CLK_HZ (CLK_HZ), .BEAT_HZ (BEAT_HZ), .ADDR_W (8), .NOTE_W (8), .OCTAVES (5)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .pause (pause), .stop (stop),
      .loop_en (loop_en), .song_len (song_len), .rom_addr (rom_addr),
      .rom_note (rom_note), .tone (tone), .audio (audio), .busy (busy), .done (done)
   );

   // clock
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int ncyc = 0;
   int mark = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int base_tab [7] = '{262, 294, 330, 349, 392, 440, 494};

   function automatic int tone_of(input int n);
      if (n == 0 || n > 35) return 20000;
      return base_tab[(n - 1) % 7] * (2 ** ((n - 1) / 7));
   endfunction

   function automatic int hp_of(input int n);
      if (n == 0 || n > 35) return 0;
      return (CLK_HZ / (2 * base_tab[(n - 1) % 7])) / (2 ** ((n - 1) / 7));
   endfunction

   bit m_active = 0, m_fetch = 0, m_done = 0;
   int m_addr = 0, m_note = 0, m_played = 0, m_tone = 20000;

   task automatic model_reset();
      m_active = 0; m_fetch = 0; m_done = 0;
      m_addr = 0; m_note = 0; m_played = 0; m_tone = 20000;
   endtask

   task automatic model_step();
      m_done = 0;
      if (stop) begin
         m_active = 0; m_fetch = 0; m_addr = 0; m_tone = 20000;
      end else if (start && song_len != 0) begin
         m_active = 1; m_fetch = 1; m_addr = 0;
      end else if (m_active) begin
         if (m_fetch) begin
            m_fetch = 0; m_note = rom[m_addr]; m_played = 0; m_tone = tone_of(m_note);
         end else if (!pause) begin
            m_played++;
            if (m_played == CPB) begin
               if (m_addr == int'(song_len) - 1) begin
                  if (loop_en) begin
                     m_addr = 0; m_fetch = 1;
                  end else begin
                     m_active = 0; m_done = 1; m_tone = 20000; m_addr = 0;
                  end
               end else begin
                  m_addr++; m_fetch = 1;
               end
            end
         end
      end
   endtask

   // Audio is high in the odd half-periods of the time the note has sounded.
   function automatic logic exp_audio();
      int hp;
      if (!m_active || m_fetch || tone_of(m_note) == 20000) return 1'b0;
      hp = hp_of(m_note);
      return ((m_played / hp) % 2) == 1;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", {31'd0, busy}, {31'd0, m_active});
         chk("rom_addr", {24'd0, rom_addr}, 32'(m_addr));
         chk("tone", tone, 32'(m_tone));
         chk("audio", {31'd0, audio}, {31'd0, exp_audio()});
         chk("done", {31'd0, done}, {31'd0, m_done});
         if (done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      ncyc++;
   endtask

   task automatic go(input int k);
      while (ncyc - mark < k) tick();
   endtask

   task automatic begin_run(input int len, input logic lp);
      song_len = 8'(len);
      loop_en  = lp;
      mark     = ncyc;
      start    = 1'b1;
      go(1);
      start    = 1'b0;
   endtask

   int dc0;

   initial begin
      rst = 1'b1; start = 0; pause = 0; stop = 0; loop_en = 0; song_len = 0;
      for (int i = 0; i < 256; i++) rom[i] = 8'd0;

      // model pins
      chk("model_tone_1", 32'(tone_of(1)), 32'd262);
      chk("model_tone_15", 32'(tone_of(15)), 32'd1048);
      chk("model_hp_8", 32'(hp_of(8)), 32'd95);
      chk("model_hp_6", 32'(hp_of(6)), 32'd113);
      chk("model_tone_36", 32'(tone_of(36)), 32'd20000);

      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_tone", tone, 32'd20000);
      chk("rst_audio", {31'd0, audio}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_addr", {24'd0, rom_addr}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);

      // one-shot {1, 8, 15}
      rom[0] = 8'd1; rom[1] = 8'd8; rom[2] = 8'd15;
      begin_run(3, 1'b0);
      chk("s1_busy_fetch", {31'd0, busy}, 32'd1);
      go(2);    chk("s1_tone0", tone, 32'd262);
      go(191);  chk("s1_aud_191", {31'd0, audio}, 32'd0);
      go(192);  chk("s1_aud_192", {31'd0, audio}, 32'd1);
      go(381);  chk("s1_aud_381", {31'd0, audio}, 32'd1);
      go(382);  chk("s1_aud_382", {31'd0, audio}, 32'd0);
      go(1002); chk("s1_addr1", {24'd0, rom_addr}, 32'd1);
      go(1003); chk("s1_tone1", tone, 32'd524);
      go(1097); chk("s1_aud_1097", {31'd0, audio}, 32'd0);
      go(1098); chk("s1_aud_1098", {31'd0, audio}, 32'd1);
      go(2004); chk("s1_tone2", tone, 32'd1048);
      go(2050); chk("s1_aud_2050", {31'd0, audio}, 32'd0);
      go(2051); chk("s1_aud_2051", {31'd0, audio}, 32'd1);
      go(3003); chk("s1_done_early", {31'd0, done}, 32'd0);
      go(3004); chk("s1_done", {31'd0, done}, 32'd1);
                chk("s1_busy_end", {31'd0, busy}, 32'd0);
      go(3005); chk("s1_done_once", 32'(done_cnt), 32'd1);

      // loop {6, 0}
      dc0 = done_cnt;
      rom[0] = 8'd6; rom[1] = 8'd0;
      begin_run(2, 1'b1);
      go(2);    chk("s2_tone0", tone, 32'd440);
      go(114);  chk("s2_aud_114", {31'd0, audio}, 32'd0);
      go(115);  chk("s2_aud_115", {31'd0, audio}, 32'd1);
      go(1002); chk("s2_addr1", {24'd0, rom_addr}, 32'd1);
      go(1003); chk("s2_tone_sil", tone, 32'd20000);
      go(1500); chk("s2_aud_sil", {31'd0, audio}, 32'd0);
      go(2003); chk("s2_wrap_addr", {24'd0, rom_addr}, 32'd0);
                chk("s2_wrap_busy", {31'd0, busy}, 32'd1);
      go(2004); chk("s2_tone_again", tone, 32'd440);
      go(4500); stop = 1'b1;
      go(4501); stop = 1'b0;
      chk("s2_stopped", {31'd0, busy}, 32'd0);
      chk("s2_no_done", 32'(done_cnt), 32'(dc0));

      // pause 500 cycles mid-note
      rom[0] = 8'd1;
      begin_run(1, 1'b0);
      go(300);  chk("s3_aud_300", {31'd0, audio}, 32'd1);
      pause = 1'b1;
      go(500);  chk("s3_aud_frozen", {31'd0, audio}, 32'd1);
      go(800);  chk("s3_aud_800", {31'd0, audio}, 32'd1);
      pause = 1'b0;
      go(1002); chk("s3_not_done", {31'd0, done}, 32'd0);
      go(1501); chk("s3_busy_1501", {31'd0, busy}, 32'd1);
      go(1502); chk("s3_done_late", {31'd0, done}, 32'd1);
      go(1503);

      // stop and start together during PLAY
      dc0 = done_cnt;
      rom[0] = 8'd1; rom[1] = 8'd8; rom[2] = 8'd15;
      begin_run(3, 1'b0);
      go(300);  stop = 1'b1; start = 1'b1;
      go(301);  stop = 1'b0; start = 1'b0;
      chk("s4_idle", {31'd0, busy}, 32'd0);
      chk("s4_tone", tone, 32'd20000);
      chk("s4_audio", {31'd0, audio}, 32'd0);
      go(3600); chk("s4_no_done", 32'(done_cnt), 32'(dc0));

      // start with song_len = 0
      begin_run(0, 1'b0);
      chk("s5_busy", {31'd0, busy}, 32'd0);
      go(5);    chk("s5_busy_later", {31'd0, busy}, 32'd0);
      chk("s5_no_done", 32'(done_cnt), 32'(dc0));

      // index 36 silent, index 35 top note
      rom[0] = 8'd36; rom[1] = 8'd35;
      begin_run(2, 1'b0);
      go(2);    chk("s6_tone36", tone, 32'd20000);
      go(500);  chk("s6_aud36", {31'd0, audio}, 32'd0);
      go(1003); chk("s6_tone35", tone, 32'd7904);
      go(1008); chk("s6_aud_1008", {31'd0, audio}, 32'd0);
      go(1009); chk("s6_aud_1009", {31'd0, audio}, 32'd1);
      go(2003); chk("s6_done", {31'd0, done}, 32'd1);
      go(2010);

      // asynchronous reset mid-play
      rom[0] = 8'd1;
      begin_run(1, 1'b0);
      go(300);  chk("s7_aud_pre", {31'd0, audio}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("s7_busy", {31'd0, busy}, 32'd0);
      chk("s7_tone", tone, 32'd20000);
      chk("s7_audio", {31'd0, audio}, 32'd0);
      chk("s7_addr", {24'd0, rom_addr}, 32'd0);
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("s7_idle", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
